// File: rtl/if_id_stage_pkg.sv
`default_nettype none
// ==========================================================================
// if_id_stage_pkg : shared widths, immediate-select codes, opcodes, states
// Rev 1.0
// ==========================================================================
package if_id_stage_pkg;

  localparam int INST_WIDTH    = 32;
  localparam int REG_WIDTH     = 32;
  localparam int IMM_WIDTH     = 25;
  localparam int IMM_SEL_WIDTH = 3;

  localparam logic [IMM_SEL_WIDTH-1:0] IMM_SEL_I    = 3'd0;
  localparam logic [IMM_SEL_WIDTH-1:0] IMM_SEL_S    = 3'd1;
  localparam logic [IMM_SEL_WIDTH-1:0] IMM_SEL_B    = 3'd2;
  localparam logic [IMM_SEL_WIDTH-1:0] IMM_SEL_U    = 3'd3;
  localparam logic [IMM_SEL_WIDTH-1:0] IMM_SEL_J    = 3'd4;
  localparam logic [IMM_SEL_WIDTH-1:0] IMM_SEL_NONE = 3'd7;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage
`default_nettype wire

// File: rtl/if_id_stage_inst_pre_dec.sv
`default_nettype none
// ==========================================================================
// inst_pre_dec : opcode -> immediate format and illegal flag (combinational)
// Rev 1.0
// ==========================================================================
module inst_pre_dec
  import if_id_stage_pkg::*;
#(
  parameter int INST_WIDTH    = 32,
  parameter int IMM_SEL_WIDTH = 3
) (
  input  logic [INST_WIDTH-1:0]    inst_i,
  output logic [IMM_SEL_WIDTH-1:0] imm_sel_o,
  output logic                     illegal_o
);

  always_comb begin
    imm_sel_o = IMM_SEL_NONE;
    illegal_o = 1'b0;
    case (inst_i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: imm_sel_o = IMM_SEL_I;
      OPC_STORE:                                  imm_sel_o = IMM_SEL_S;
      OPC_BRANCH:                                 imm_sel_o = IMM_SEL_B;
      OPC_LUI, OPC_AUIPC:                         imm_sel_o = IMM_SEL_U;
      OPC_JAL:                                    imm_sel_o = IMM_SEL_J;
      OPC_OP:                                     imm_sel_o = IMM_SEL_NONE;
      default:                                    illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ==========================================================================
// if_id_stage : IF/ID register with two-entry skid buffer and pre-decode
// Rev 1.0
// ==========================================================================
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int INST_WIDTH    = if_id_stage_pkg::INST_WIDTH,
  parameter int REG_WIDTH     = if_id_stage_pkg::REG_WIDTH,
  parameter int IMM_WIDTH     = if_id_stage_pkg::IMM_WIDTH,
  parameter int IMM_SEL_WIDTH = if_id_stage_pkg::IMM_SEL_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INST_WIDTH-1:0]    in_inst,
  input  logic [REG_WIDTH-1:0]     in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INST_WIDTH-1:0]    out_inst,
  output logic [REG_WIDTH-1:0]     out_pc,
  output logic [IMM_WIDTH-1:0]     imm_in,
  output logic [IMM_SEL_WIDTH-1:0] imm_sel,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic                     illegal
);

  logic [INST_WIDTH-1:0]    main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic [REG_WIDTH-1:0]     main_pc_q,   main_pc_d,   skid_pc_q,   skid_pc_d;
  logic [IMM_SEL_WIDTH-1:0] main_sel_q,  main_sel_d,  skid_sel_q,  skid_sel_d;
  logic                     main_ill_q,  main_ill_d,  skid_ill_q,  skid_ill_d;
  logic                     main_vld_q,  main_vld_d,  skid_vld_q,  skid_vld_d;

  logic [IMM_SEL_WIDTH-1:0] dec_sel;
  logic                     dec_ill;
  logic                     push, pop;
  buf_state_e               state;

  inst_pre_dec #(
    .INST_WIDTH   (INST_WIDTH),
    .IMM_SEL_WIDTH(IMM_SEL_WIDTH)
  ) u_pre_dec (
    .inst_i   (in_inst),
    .imm_sel_o(dec_sel),
    .illegal_o(dec_ill)
  );

  always_comb begin
    if (!main_vld_q)     state = ST_EMPTY;
    else if (skid_vld_q) state = ST_FULL;
    else                 state = ST_ONE;
  end

  assign push = in_valid & in_ready;
  assign pop  = main_vld_q & out_ready;

  always_comb begin
    main_inst_d = main_inst_q;  main_pc_d = main_pc_q;
    main_sel_d  = main_sel_q;   main_ill_d = main_ill_q;
    main_vld_d  = main_vld_q;
    skid_inst_d = skid_inst_q;  skid_pc_d = skid_pc_q;
    skid_sel_d  = skid_sel_q;   skid_ill_d = skid_ill_q;
    skid_vld_d  = skid_vld_q;
    case (state)
      ST_EMPTY: begin
        if (push) begin
          main_inst_d = in_inst; main_pc_d = in_pc;
          main_sel_d  = dec_sel; main_ill_d = dec_ill;
          main_vld_d  = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_inst_d = in_inst; main_pc_d = in_pc;
          main_sel_d  = dec_sel; main_ill_d = dec_ill;
        end else if (push) begin
          skid_inst_d = in_inst; skid_pc_d = in_pc;
          skid_sel_d  = dec_sel; skid_ill_d = dec_ill;
          skid_vld_d  = 1'b1;
        end else if (pop) begin
          main_vld_d = 1'b0;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_inst_d = skid_inst_q; main_pc_d = skid_pc_q;
          main_sel_d  = skid_sel_q;  main_ill_d = skid_ill_q;
          skid_vld_d  = 1'b0;
        end
      end
      default: ;
    endcase
    // Flush drops validity only; data registers keep their last contents.
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_inst_q <= '0; main_pc_q <= '0; main_sel_q <= IMM_SEL_NONE;
      main_ill_q  <= 1'b0; main_vld_q <= 1'b0;
      skid_inst_q <= '0; skid_pc_q <= '0; skid_sel_q <= IMM_SEL_NONE;
      skid_ill_q  <= 1'b0; skid_vld_q <= 1'b0;
    end else begin
      main_inst_q <= main_inst_d; main_pc_q <= main_pc_d; main_sel_q <= main_sel_d;
      main_ill_q  <= main_ill_d;  main_vld_q <= main_vld_d;
      skid_inst_q <= skid_inst_d; skid_pc_q <= skid_pc_d; skid_sel_q <= skid_sel_d;
      skid_ill_q  <= skid_ill_d;  skid_vld_q <= skid_vld_d;
    end
  end

  assign in_ready  = ~skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_inst  = main_inst_q;
  assign out_pc    = main_pc_q;
  assign imm_in    = main_inst_q[INST_WIDTH-1:7];
  assign imm_sel   = main_sel_q;
  assign illegal   = main_ill_q;
  assign rs1       = main_inst_q[19:15];
  assign rs2       = main_inst_q[24:20];
  assign rd        = main_inst_q[11:7];

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ==========================================================================
// tb_if_id_stage : directed self-checking bench for if_id_stage
// Rev 1.0
// ==========================================================================
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] in_inst, in_pc, out_inst, out_pc;
  logic [24:0] imm_in;
  logic [2:0]  imm_sel;
  logic [4:0]  rs1, rs2, rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .imm_in(imm_in), .imm_sel(imm_sel), .rs1(rs1), .rs2(rs2), .rd(rd), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ovalid"}, out_valid, 0);
    chk({tag, "_iready"}, in_ready, 1);
    chk({tag, "_inst"}, out_inst, 0);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_imm"}, imm_in, 0);
    chk({tag, "_sel"}, imm_sel, 7);
    chk({tag, "_ill"}, illegal, 0);
    chk({tag, "_regs"}, {rs1, rs2, rd}, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    #12;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    step();

    // addi x1,x2,5
    drive(1'b1, 32'h00510093, 32'h100);
    step();
    chk("addi_valid", out_valid, 1);
    chk("addi_imm", imm_in, 25'h000A201);
    chk("addi_sel", imm_sel, 0);
    chk("addi_rs1", rs1, 2);
    chk("addi_rd", rd, 1);
    chk("addi_ill", illegal, 0);
    chk("addi_pc", out_pc, 32'h100);

    // sw then beq back-to-back
    drive(1'b1, 32'h00512423, 32'h104);
    step();
    chk("sw_sel", imm_sel, 1);
    chk("sw_rs1", rs1, 2);
    chk("sw_rs2", rs2, 5);
    chk("sw_valid", out_valid, 1);
    drive(1'b1, 32'h00000063, 32'h108);
    step();
    chk("beq_sel", imm_sel, 2);
    chk("beq_pc", out_pc, 32'h108);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_hold", out_inst, 32'h00000063);

    // backpressure: three instructions, out_ready low
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h200);
    step();
    chk("bp1_inst", out_inst, 32'h00100093);
    chk("bp1_iready", in_ready, 1);
    drive(1'b1, 32'h00200113, 32'h204);
    step();
    chk("bp2_iready", in_ready, 0);
    chk("bp2_inst", out_inst, 32'h00100093);
    drive(1'b1, 32'h00300193, 32'h208);
    step();
    chk("bp3_hold_inst", out_inst, 32'h00100093);
    chk("bp3_hold_rdy", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("bp_out2", out_inst, 32'h00200113);
    chk("bp_out2_pc", out_pc, 32'h204);
    chk("bp_out2_rdy", in_ready, 1);
    step();
    chk("bp_out3", out_inst, 32'h00300193);
    chk("bp_out3_valid", out_valid, 1);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("bp_empty", out_valid, 0);

    // flush while FULL with out_ready high
    out_ready = 1'b0;
    drive(1'b1, 32'h00400213, 32'h300);
    step();
    drive(1'b1, 32'h00500293, 32'h304);
    step();
    chk("fl_full", in_ready, 0);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_ovalid", out_valid, 0);
    chk("fl_iready", in_ready, 1);
    step();
    chk("fl_stay_empty", out_valid, 0);

    // flush discards an instruction accepted in the same cycle
    drive(1'b1, 32'h00600313, 32'h308);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_in_drop", out_valid, 0);

    // illegal and other formats
    drive(1'b1, 32'hFFFFFFFF, 32'h400);
    step();
    chk("ill_flag", illegal, 1);
    chk("ill_sel", imm_sel, 7);
    chk("ill_pass", {out_valid, out_inst}, {1'b1, 32'hFFFFFFFF});
    drive(1'b1, 32'h002081B3, 32'h404);
    step();
    chk("r_ill", illegal, 0);
    chk("r_sel", imm_sel, 7);
    chk("r_rd", rd, 3);
    drive(1'b1, 32'h000010B7, 32'h408);
    step();
    chk("lui_sel", imm_sel, 3);
    drive(1'b1, 32'h0000006F, 32'h40C);
    step();
    chk("jal_sel", imm_sel, 4);
    drive(1'b1, 32'h00000073, 32'h410);
    step();
    chk("sys_sel", imm_sel, 0);

    // async reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h00700393, 32'h500);
    step();
    drive(1'b1, 32'h00800413, 32'h504);
    step();
    chk("ar_full", in_ready, 0);
    drive(1'b0, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("arst_no_stale", out_valid, 0);
    step();
    chk("arst_no_stale2", {out_valid, out_inst}, 33'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
